// File: rtl/sif_pkg.sv
// sif_pkg: shared types and constants for the SIF responder slice.
//   SIF_AW / SIF_DW : bus address / data widths
//   sif_op_t        : xa strobe decode {wr, rd}
//   wa_entry_t      : one posted wa write {addr, data}
//   sif_decode()    : packs the two xa strobes into a sif_op_t
package sif_pkg;

  localparam int unsigned SIF_AW = 16;
  localparam int unsigned SIF_DW = 16;

  typedef enum logic [1:0] {
    SifNop  = 2'b00,
    SifRd   = 2'b01,
    SifWr   = 2'b10,
    SifRdWr = 2'b11
  } sif_op_t;

  typedef struct packed {
    logic [SIF_AW-1:0] addr;
    logic [SIF_DW-1:0] data;
  } wa_entry_t;

  function automatic sif_op_t sif_decode(input logic wr, input logic rd);
    return sif_op_t'({wr, rd});
  endfunction

endpackage

// File: rtl/sif_wa_fifo.sv
// sif_wa_fifo: synchronous FIFO of wa_entry_t holding posted wa writes.
// Ports:
//   clk_i, nrst_i : clock, synchronous active-low reset (empties the FIFO)
//   i_push/i_data : push request and entry
//   i_pop         : pop request (head advances when non-empty)
//   o_data        : head entry (meaningful when !o_empty)
//   o_full/o_empty/o_count : occupancy status
// A push while full is accepted only if a pop happens in the same cycle.
module sif_wa_fifo
  import sif_pkg::*;
#(
  parameter int unsigned DEPTH = 4
) (
  input  logic                    clk_i,
  input  logic                    nrst_i,
  input  logic                    i_push,
  input  wa_entry_t               i_data,
  input  logic                    i_pop,
  output wa_entry_t               o_data,
  output logic                    o_full,
  output logic                    o_empty,
  output logic [$clog2(DEPTH):0]  o_count
);

  localparam int unsigned PtrW = $clog2(DEPTH);

  wa_entry_t         r_mem [DEPTH];
  logic [PtrW-1:0]   r_wr_ptr;
  logic [PtrW-1:0]   r_rd_ptr;
  logic [PtrW:0]     r_count;
  logic              w_push_ok;
  logic              w_pop_ok;

  always_comb begin
    o_count   = r_count;
    o_full    = (r_count == (PtrW + 1)'(DEPTH));
    o_empty   = (r_count == '0);
    o_data    = r_mem[r_rd_ptr];
    w_pop_ok  = i_pop && !o_empty;
    w_push_ok = i_push && (!o_full || w_pop_ok);
  end

  // Pointers wrap naturally since DEPTH is a power of two.
  always_ff @(posedge clk_i) begin
    if (!nrst_i) begin
      r_wr_ptr <= '0;
      r_rd_ptr <= '0;
      r_count  <= '0;
    end else begin
      if (w_push_ok) r_wr_ptr <= r_wr_ptr + PtrW'(1);
      if (w_pop_ok)  r_rd_ptr <= r_rd_ptr + PtrW'(1);
      case ({w_push_ok, w_pop_ok})
        2'b10:   r_count <= r_count + (PtrW + 1)'(1);
        2'b01:   r_count <= r_count - (PtrW + 1)'(1);
        default: r_count <= r_count;
      endcase
    end
  end

  always_ff @(posedge clk_i) begin
    if (w_push_ok) r_mem[r_wr_ptr] <= i_data;
  end

endmodule

// File: rtl/sif_responder.sv
// sif_responder: SIF bus target with a bank of NUM_REGS 16-bit registers.
//   xa_*  : initiator read/write strobes; reads answer with 1-cycle latency
//   wa_*  : posted writes, queued in sif_wa_fifo and drained on cycles without an xa write
//   err_* : sticky error flags (wa overflow, address range, xa protocol), cleared by err_clr_i
// Reset is synchronous active-low (nrst_i) and discards queued wa writes.
// Optional: SIF_RD_BYPASS_EN forwards same-cycle drain data to an xa read of that address;
// without it a read sees the pre-write bank contents.
module sif_responder
  import sif_pkg::*;
#(
  parameter int unsigned NUM_REGS = 16,
  parameter int unsigned WA_DEPTH = 4
) (
  input  logic              clk_i,
  input  logic              nrst_i,
  input  logic [SIF_AW-1:0] xa_addr_i,
  input  logic [SIF_DW-1:0] xa_data_wr_i,
  input  logic              xa_wr_s_i,
  input  logic              xa_rd_s_i,
  output logic [SIF_DW-1:0] xa_data_rd_o,
  output logic              xa_rd_vld_o,
  input  logic [SIF_AW-1:0] wa_addr_i,
  input  logic [SIF_DW-1:0] wa_data_wr_i,
  input  logic              wa_wr_s_i,
  output logic              wa_full_o,
  input  logic              err_clr_i,
  output logic              wa_ovf_o,
  output logic              addr_err_o,
  output logic              proto_err_o
);

  localparam int unsigned IdxW = (NUM_REGS > 1) ? $clog2(NUM_REGS) : 1;

  logic [SIF_DW-1:0]         r_bank [NUM_REGS];
  logic [SIF_DW-1:0]         r_rd_data;
  logic                      r_rd_vld;
  logic                      r_wa_ovf;
  logic                      r_addr_err;
  logic                      r_proto_err;

  sif_op_t                   w_op;
  logic                      w_xa_wr;
  logic                      w_xa_rd;
  logic                      w_proto;
  logic                      w_xa_in;
  logic                      w_wa_in;
  logic [IdxW-1:0]           w_xa_idx;
  logic [IdxW-1:0]           w_wa_idx;
  logic                      w_pop;
  logic                      w_fifo_full;
  logic                      w_fifo_empty;
  logic [$clog2(WA_DEPTH):0] w_fifo_count;
  wa_entry_t                 w_push_entry;
  wa_entry_t                 w_head;
  logic [SIF_DW-1:0]         w_rd_val;
  logic                      w_ovf_set;
  logic                      w_addr_set;

  // xa decode: a simultaneous read+write performs only the write.
  always_comb begin
    w_op    = sif_decode(xa_wr_s_i, xa_rd_s_i);
    w_xa_wr = 1'b0;
    w_xa_rd = 1'b0;
    w_proto = 1'b0;
    unique case (w_op)
      SifRd:   w_xa_rd = 1'b1;
      SifWr:   w_xa_wr = 1'b1;
      SifRdWr: begin
        w_xa_wr = 1'b1;
        w_proto = 1'b1;
      end
      default: ;
    endcase
  end

  assign w_push_entry = '{addr: wa_addr_i, data: wa_data_wr_i};

  // xa writes own the bank write port; the FIFO drains only when it is free.
  assign w_pop = !w_fifo_empty && !w_xa_wr;

  sif_wa_fifo #(
    .DEPTH (WA_DEPTH)
  ) u_wa_fifo (
    .clk_i   (clk_i),
    .nrst_i  (nrst_i),
    .i_push  (wa_wr_s_i),
    .i_data  (w_push_entry),
    .i_pop   (w_pop),
    .o_data  (w_head),
    .o_full  (w_fifo_full),
    .o_empty (w_fifo_empty),
    .o_count (w_fifo_count)
  );

  always_comb begin
    w_xa_in  = (32'(xa_addr_i) < NUM_REGS);
    w_wa_in  = (32'(w_head.addr) < NUM_REGS);
    w_xa_idx = xa_addr_i[IdxW-1:0];
    w_wa_idx = w_head.addr[IdxW-1:0];

    w_rd_val = '0;
    if (w_xa_in) w_rd_val = r_bank[w_xa_idx];
`ifdef SIF_RD_BYPASS_EN
    if (w_xa_in && w_pop && w_wa_in && (w_head.addr == xa_addr_i)) w_rd_val = w_head.data;
`else
`endif

    // Full-and-popping still accepts the push, so only a non-draining full FIFO drops.
    w_ovf_set  = wa_wr_s_i && w_fifo_full && !w_pop;
    w_addr_set = ((xa_wr_s_i || xa_rd_s_i) && !w_xa_in) || (w_pop && !w_wa_in);
  end

  always_ff @(posedge clk_i) begin
    if (!nrst_i) begin
      for (int i = 0; i < int'(NUM_REGS); i++) r_bank[i] <= '0;
      r_rd_data   <= '0;
      r_rd_vld    <= 1'b0;
      r_wa_ovf    <= 1'b0;
      r_addr_err  <= 1'b0;
      r_proto_err <= 1'b0;
    end else begin
      if (w_xa_wr && w_xa_in) begin
        r_bank[w_xa_idx] <= xa_data_wr_i;
      end else if (w_pop && w_wa_in) begin
        r_bank[w_wa_idx] <= w_head.data;
      end

      r_rd_vld <= w_xa_rd;
      if (w_xa_rd) r_rd_data <= w_rd_val;

      // Set beats clear.
      r_wa_ovf    <= w_ovf_set  || (r_wa_ovf    && !err_clr_i);
      r_addr_err  <= w_addr_set || (r_addr_err  && !err_clr_i);
      r_proto_err <= w_proto    || (r_proto_err && !err_clr_i);
    end
  end

  assign xa_data_rd_o = r_rd_data;
  assign xa_rd_vld_o  = r_rd_vld;
  assign wa_full_o    = w_fifo_full;
  assign wa_ovf_o     = r_wa_ovf;
  assign addr_err_o   = r_addr_err;
  assign proto_err_o  = r_proto_err;

  count_bound_a : assert property (@(posedge clk_i) disable iff (!nrst_i)
                                   32'(w_fifo_count) <= WA_DEPTH);

endmodule
